bridge_arbiter: RTL
===================

// Module: bridge_arbiter
// PURPOSE
//   Shares the single External Bridge to Avalon Master port between two requesters.
//   Port 0 is the line buffer prefetch and has priority; port 1 is a secondary
//   reader/writer (frame writer, blitter).
//   Sits in the clk_100 interface domain, between the requesters and the system interface_* bus.
//   Provides a starvation guard, a transaction timeout and a sticky error flag.
// PARAMETERS
//   ADDR_BITS       26    bridge address width (bytes)
//   DATA_BITS       128   bridge data width; byte enable width = DATA_BITS/8
//   STARVE_LIMIT    8     consecutive m0 grants while m1 pends before m1 is forced; 0 => m1 wins ties
//   TIMEOUT_CYCLES  1024  cycles in a grant state without acknowledge before abort
// PORTS
//   clk                    in   1             interface clock (clk_100)
//   reset_n                in   1             asynchronous, active-low reset
//   mN_address (N=0,1)     in   ADDR_BITS     requester byte address
//   mN_byte_enable         in   DATA_BITS/8   requester byte enables
//   mN_read                in   1             read request; held until mN_acknowledge
//   mN_write               in   1             write request; held until mN_acknowledge
//   mN_write_data          in   DATA_BITS     write data
//   mN_read_data           out  DATA_BITS     read data; valid only while mN_acknowledge=1
//   mN_acknowledge         out  1             one-cycle completion strobe
//   interface_address      out  ADDR_BITS     to bridge
//   interface_byte_enable  out  DATA_BITS/8   to bridge
//   interface_read         out  1             to bridge
//   interface_write        out  1             to bridge
//   interface_write_data   out  DATA_BITS     to bridge
//   interface_read_data    in   DATA_BITS     from bridge
//   interface_acknowledge  in   1             from bridge; completes the current transfer
//   timeout_error          out  1             sticky; set by a timeout abort
//   timeout_clear          in   1             synchronous clear of timeout_error
// BEHAVIOUR
// - reqN = mN_read | mN_write. If both are high, the write is issued and the read is dropped.
// - FSM states: IDLE, GRANT0, GRANT1. Reset (async, immediate) -> IDLE.
//   All interface_* outputs, starve_cnt, the timeout counter and timeout_error reset to 0.
//   mN_acknowledge reads 0 in IDLE.
// - IDLE -> GRANT0: req0 & (!req1 | starve_cnt < STARVE_LIMIT).
//   Else IDLE -> GRANT1 if req1. Otherwise stay in IDLE.
// - On the grant edge, the winner's address, byte enables, write data and read/write are
//   registered onto interface_*. Request-to-bridge latency is 1 cycle.
// - In GRANTn, interface_* is held constant until interface_acknowledge=1.
//   mN_acknowledge = (state==GRANTn) & (interface_acknowledge | timeout_hit). This is
//   combinational (0-cycle).
//   mN_read_data = interface_read_data on acknowledge, or 0 on a timeout abort.
// - On the acknowledge edge, interface_read/write clear and the FSM returns to IDLE.
//   The requester must drop or replace its request on that same edge.
//   Maximum throughput is one transfer per 2 cycles.
// - starve_cnt: increments (saturating at STARVE_LIMIT) on each GRANT0 entry while req1=1.
//   Clears on GRANT1 entry or in IDLE with req1=0.
// - Timeout counter: clears on grant entry and increments each GRANT cycle.
//   timeout_hit = (count == TIMEOUT_CYCLES-1) & !interface_acknowledge.
//   On timeout_hit: abort to IDLE, clear interface_read/write, set timeout_error.
//   If acknowledge arrives on that same cycle, the transfer completes normally.
// - timeout_clear clears timeout_error. A simultaneous set wins.
// - interface_acknowledge while in IDLE is ignored: no strobe, no state change.
// - Reset mid-transfer abandons the bridge transaction. No acknowledge is issued.
// TESTING
// 1. m0_read @0x100; bridge acks 5 cycles after issue with data 0xA5.. ->
//    interface_read=1 one cycle after request; m0_acknowledge in the same cycle as the
//    bridge ack, with data 0xA5..; interface_read=0 on the next cycle.
// 2. req0 and req1 held continuously, STARVE_LIMIT=8 -> grant pattern 8x m0, 1x m1, repeating.
// 3. m1_write, no bridge ack, TIMEOUT_CYCLES=1024 -> m1_acknowledge pulse on grant cycle 1024;
//    interface_write=0; timeout_error=1 until timeout_clear.
// 4. reset_n low mid-GRANT0 -> all outputs 0 immediately; after release, a new m1 request
//    is issued in 1 cycle.
// 5. interface_acknowledge pulsed in IDLE -> no mN_acknowledge, state stays IDLE.
// 6. Back-to-back m0 reads with same-cycle bridge ack -> one transfer every 2 cycles;
//    no duplicate issue.

Source files
------------

// File: rtl/bridge_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the External Bridge.
interface bridge_arbiter_if #(
    parameter int unsigned ADDR_BITS = 26,
    parameter int unsigned DATA_BITS = 128
);
    localparam int unsigned BE_BITS = DATA_BITS / 8;

    // Requester 0 (line buffer prefetch, priority)
    logic [ADDR_BITS-1:0] m0_address;
    logic [BE_BITS-1:0]   m0_byte_enable;
    logic                 m0_read;
    logic                 m0_write;
    logic [DATA_BITS-1:0] m0_write_data;
    logic [DATA_BITS-1:0] m0_read_data;
    logic                 m0_acknowledge;

    // Requester 1 (frame writer / blitter)
    logic [ADDR_BITS-1:0] m1_address;
    logic [BE_BITS-1:0]   m1_byte_enable;
    logic                 m1_read;
    logic                 m1_write;
    logic [DATA_BITS-1:0] m1_write_data;
    logic [DATA_BITS-1:0] m1_read_data;
    logic                 m1_acknowledge;

    // Bridge side
    logic [ADDR_BITS-1:0] interface_address;
    logic [BE_BITS-1:0]   interface_byte_enable;
    logic                 interface_read;
    logic                 interface_write;
    logic [DATA_BITS-1:0] interface_write_data;
    logic [DATA_BITS-1:0] interface_read_data;
    logic                 interface_acknowledge;

    // Arbiter view: serves the requesters, masters the bridge.
    modport master (
        input  m0_address, m0_byte_enable, m0_read, m0_write, m0_write_data,
        output m0_read_data, m0_acknowledge,
        input  m1_address, m1_byte_enable, m1_read, m1_write, m1_write_data,
        output m1_read_data, m1_acknowledge,
        output interface_address, interface_byte_enable, interface_read,
        output interface_write, interface_write_data,
        input  interface_read_data, interface_acknowledge
    );

    // Environment view: requesters plus bridge.
    modport slave (
        output m0_address, m0_byte_enable, m0_read, m0_write, m0_write_data,
        input  m0_read_data, m0_acknowledge,
        output m1_address, m1_byte_enable, m1_read, m1_write, m1_write_data,
        input  m1_read_data, m1_acknowledge,
        input  interface_address, interface_byte_enable, interface_read,
        input  interface_write, interface_write_data,
        output interface_read_data, interface_acknowledge
    );
endinterface

// File: rtl/bridge_arbiter.sv
// Two-port priority arbiter in front of the External Bridge, with starvation
// guard for port 1, grant timeout and a sticky timeout error flag.
module bridge_arbiter #(
    parameter int unsigned ADDR_BITS      = 26,
    parameter int unsigned DATA_BITS      = 128,
    parameter int unsigned STARVE_LIMIT   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    bridge_arbiter_if.master bus,
    output logic             timeout_error,
    input  logic             timeout_clear
);
    localparam int unsigned BE_BITS = DATA_BITS / 8;
    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 req0;
    logic                 req1;
    logic                 grant0;
    logic                 grant1;
    logic                 done;
    logic                 timeout_hit;
    logic [SW-1:0]        starve_cnt;
    logic [TW-1:0]        tmo_cnt;
    logic [ADDR_BITS-1:0] addr_q;
    logic [BE_BITS-1:0]   be_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic                 rd_q;
    logic                 wr_q;

    assign req0 = bus.m0_read | bus.m0_write;
    assign req1 = bus.m1_read | bus.m1_write;

    // Timeout fires only when the last allowed cycle passes without an acknowledge.
    assign timeout_hit = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1))
                         && !bus.interface_acknowledge;
    assign done = bus.interface_acknowledge | timeout_hit;

    assign bus.interface_address     = addr_q;
    assign bus.interface_byte_enable = be_q;
    assign bus.interface_write_data  = wdata_q;
    assign bus.interface_read        = rd_q;
    assign bus.interface_write       = wr_q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Arbitration, next state and zero-latency completion strobes.
    always_comb begin
        state_nxt          = state;
        grant0             = 1'b0;
        grant1             = 1'b0;
        bus.m0_acknowledge = 1'b0;
        bus.m1_acknowledge = 1'b0;
        bus.m0_read_data   = '0;
        bus.m1_read_data   = '0;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || (starve_cnt < SW'(STARVE_LIMIT)))) begin
                    state_nxt = GRANT0;
                    grant0    = 1'b1;
                end else if (req1) begin
                    state_nxt = GRANT1;
                    grant1    = 1'b1;
                end
            end
            GRANT0: begin
                bus.m0_acknowledge = done;
                if (bus.interface_acknowledge) bus.m0_read_data = bus.interface_read_data;
                if (done) state_nxt = IDLE;
            end
            GRANT1: begin
                bus.m1_acknowledge = done;
                if (bus.interface_acknowledge) bus.m1_read_data = bus.interface_read_data;
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bridge request registers: load on grant, drop strobes on completion/abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else if (grant0) begin
            addr_q  <= bus.m0_address;
            be_q    <= bus.m0_byte_enable;
            wdata_q <= bus.m0_write_data;
            rd_q    <= bus.m0_read & ~bus.m0_write;
            wr_q    <= bus.m0_write;
        end else if (grant1) begin
            addr_q  <= bus.m1_address;
            be_q    <= bus.m1_byte_enable;
            wdata_q <= bus.m1_write_data;
            rd_q    <= bus.m1_read & ~bus.m1_write;
            wr_q    <= bus.m1_write;
        end else if ((state != IDLE) && done) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end
    end

    // Starvation counter: consecutive port-0 wins while port 1 is waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (grant1 || ((state == IDLE) && !req1)) begin
            starve_cnt <= '0;
        end else if (grant0 && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Grant-cycle counter for the timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              tmo_cnt <= '0;
        else if (grant0 || grant1) tmo_cnt <= '0;
        else if (state != IDLE)    tmo_cnt <= tmo_cnt + TW'(1);
    end

    // Sticky error: a new abort beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         timeout_error <= 1'b0;
        else if (timeout_hit) timeout_error <= 1'b1;
        else if (timeout_clear) timeout_error <= 1'b0;
    end
endmodule
